// File: rtl/custom_instr_sched_pkg.sv
// Shared types for the custom-instruction scheduler.
// - custom_instr_t : custom op kind as decoded by the CPU
// - sched_state_t  : scheduler FSM state
// - NUM_ACC        : number of accelerator units (FFT, ENCRYPT, DECRYPT)
// - kind_onehot()  : maps an op kind to its accelerator request bit
package custom_instr_sched_pkg;

    localparam int NUM_ACC = 3;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        FFT     = 2'd1,
        ENCRYPT = 2'd2,
        DECRYPT = 2'd3
    } custom_instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Unit k serves kind k+1; NONE selects no unit.
    function automatic logic [NUM_ACC-1:0] kind_onehot(input custom_instr_t kind);
        logic [NUM_ACC-1:0] oh;
        oh = '0;
        case (kind)
            FFT:     oh = 3'b001;
            ENCRYPT: oh = 3'b010;
            DECRYPT: oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/custom_instr_sched_if.sv
// CPU-side and accelerator-side signals of the custom-instruction scheduler.
// - master : scheduler view (takes CPU op and accelerator ack/done/result,
//            drives stall, result strobe, requests and latched operands)
// - slave  : environment view (CPU pipeline plus the three accelerators)
// DATA_W must match the DATA_W of the connected scheduler.
interface custom_instr_sched_if
    import custom_instr_sched_pkg::*;
#(
    parameter int DATA_W = 19
);
    logic                        cpu_valid_i;
    custom_instr_t               cpu_kind_i;
    logic [DATA_W-1:0]           cpu_opr_a_i;
    logic [DATA_W-1:0]           cpu_opr_b_i;
    logic                        cpu_stall_o;
    logic                        cpu_res_valid_o;
    logic [DATA_W-1:0]           cpu_res_o;
    logic                        cpu_err_o;
    logic [NUM_ACC-1:0]          acc_req_o;
    logic [DATA_W-1:0]           acc_opr_a_o;
    logic [DATA_W-1:0]           acc_opr_b_o;
    logic [NUM_ACC-1:0]          acc_ack_i;
    logic [NUM_ACC-1:0]          acc_done_i;
    logic [NUM_ACC*DATA_W-1:0]   acc_res_i;

    modport master (
        input  cpu_valid_i, cpu_kind_i, cpu_opr_a_i, cpu_opr_b_i,
        input  acc_ack_i, acc_done_i, acc_res_i,
        output cpu_stall_o, cpu_res_valid_o, cpu_res_o, cpu_err_o,
        output acc_req_o, acc_opr_a_o, acc_opr_b_o
    );

    modport slave (
        output cpu_valid_i, cpu_kind_i, cpu_opr_a_i, cpu_opr_b_i,
        output acc_ack_i, acc_done_i, acc_res_i,
        input  cpu_stall_o, cpu_res_valid_o, cpu_res_o, cpu_err_o,
        input  acc_req_o, acc_opr_a_o, acc_opr_b_o
    );
endinterface

// File: rtl/custom_instr_sched_timeout_ctr.sv
// Timeout counter for one in-flight custom op.
// - clk, reset_n : clock, asynchronous active-low reset
// - clear        : restart from 0 (op accepted)
// - enable       : count this cycle (op in ISSUE or WAIT)
// - tc           : count has reached TIMEOUT_CYCLES-1
module custom_instr_sched_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // The count may wrap once past TERMINAL on the abort cycle; it is always
    // cleared again before the next op starts counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/custom_instr_sched.sv
// Custom-instruction scheduler: takes one FFT/ENCRYPT/DECRYPT op from the
// CPU, stalls the pipeline, issues the op to the selected accelerator over a
// req/ack handshake, waits for done (or times out) and returns a one-cycle
// result strobe for the MEM-path write-back mux.
// Ports:
// - clk, reset_n        : clock, asynchronous active-low reset
// - bus (master)        : CPU op/stall/result and accelerator req/ack/done
// - busy_o              : scheduler not in IDLE
// - perf_done_cnt_o     : ops completed normally (saturating)
// - perf_timeout_cnt_o  : ops aborted by timeout (saturating)
// Build option: define SCHED_PERF_CNT_EN to build the performance counters;
// otherwise both perf ports read 0. Core timing is the same either way.
module custom_instr_sched
    import custom_instr_sched_pkg::*;
#(
    parameter int DATA_W         = 19,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    custom_instr_sched_if.master  bus,
    output logic                  busy_o,
    output logic [15:0]           perf_done_cnt_o,
    output logic [15:0]           perf_timeout_cnt_o
);
    sched_state_t        state, state_next;
    custom_instr_t       kind_q;
    logic [DATA_W-1:0]   opr_a_q, opr_b_q;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                err_q, err_d;
    logic [NUM_ACC-1:0]  kind_oh;
    logic [DATA_W-1:0]   sel_res;
    logic                accept, sel_ack, sel_done, timeout_tc;
    logic                stall, res_valid;
    logic [NUM_ACC-1:0]  acc_req;

    assign accept   = (state == IDLE) && bus.cpu_valid_i && (bus.cpu_kind_i != NONE);
    assign kind_oh  = kind_onehot(kind_q);
    // Ack/done from units other than the selected one are masked off here.
    assign sel_ack  = |(bus.acc_ack_i & kind_oh);
    assign sel_done = |(bus.acc_done_i & kind_oh);

    // Result mux: pick the selected unit's slice of the packed result bus.
    always_comb begin
        sel_res = '0;
        case (kind_q)
            FFT:     sel_res = bus.acc_res_i[0*DATA_W +: DATA_W];
            ENCRYPT: sel_res = bus.acc_res_i[1*DATA_W +: DATA_W];
            DECRYPT: sel_res = bus.acc_res_i[2*DATA_W +: DATA_W];
            default: sel_res = '0;
        endcase
    end

    custom_instr_sched_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  ((state == ISSUE) || (state == WAIT)),
        .tc      (timeout_tc)
    );

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        res_d      = res_q;
        err_d      = err_q;
        acc_req    = '0;
        stall      = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                stall   = 1'b1;
                acc_req = kind_oh;
                if (sel_ack && sel_done) begin
                    res_d      = sel_res;
                    err_d      = 1'b0;
                    state_next = RESP;
                end else if (timeout_tc) begin
                    res_d      = '0;
                    err_d      = 1'b1;
                    state_next = RESP;
                end else if (sel_ack) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                // A done on the terminal cycle still wins over the timeout.
                if (sel_done) begin
                    res_d      = sel_res;
                    err_d      = 1'b0;
                    state_next = RESP;
                end else if (timeout_tc) begin
                    res_d      = '0;
                    err_d      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                res_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            kind_q  <= NONE;
            opr_a_q <= '0;
            opr_b_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            res_q <= res_d;
            err_q <= err_d;
            if (accept) begin
                kind_q  <= bus.cpu_kind_i;
                opr_a_q <= bus.cpu_opr_a_i;
                opr_b_q <= bus.cpu_opr_b_i;
            end
        end
    end

    // acc_req_o is decoded from registered state, so reset drops it at once.
    assign bus.acc_req_o       = acc_req;
    assign bus.acc_opr_a_o     = opr_a_q;
    assign bus.acc_opr_b_o     = opr_b_q;
    assign bus.cpu_stall_o     = stall;
    assign bus.cpu_res_valid_o = res_valid;
    assign bus.cpu_res_o       = res_q;
    assign bus.cpu_err_o       = err_q;
    assign busy_o              = (state != IDLE);

`ifdef SCHED_PERF_CNT_EN
    logic [15:0] done_cnt, timeout_cnt;

    // Each op is counted once, in its RESP cycle, and the counters hold at max.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_cnt    <= '0;
            timeout_cnt <= '0;
        end else if (state == RESP) begin
            if (err_q) begin
                if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
            end else begin
                if (done_cnt != 16'hFFFF) done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    assign perf_done_cnt_o    = done_cnt;
    assign perf_timeout_cnt_o = timeout_cnt;
`else
    assign perf_done_cnt_o    = 16'd0;
    assign perf_timeout_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_custom_instr_sched.sv
// Testbench for custom_instr_sched (TIMEOUT_CYCLES = 8). A transaction-level
// model (op in flight, cycles spent, acked yet, response pending) predicts
// the outputs; a compare process checks them on every falling edge, and the
// directed op sequences check latency/result/error against literal values.
module tb_custom_instr_sched;
    import custom_instr_sched_pkg::*;

    localparam int DATA_W = 19;
    localparam int T      = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        busy;
    logic [15:0] perf_done, perf_to;

    always #5 clk = ~clk;

    custom_instr_sched_if #(.DATA_W(DATA_W)) bus ();

    custom_instr_sched #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .bus                (bus),
        .busy_o             (busy),
        .perf_done_cnt_o    (perf_done),
        .perf_timeout_cnt_o (perf_to)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic              m_busy, m_acked, m_resp, m_err;
    int                m_age;
    custom_instr_t     m_kind;
    logic [DATA_W-1:0] m_a, m_b, m_res;
    int                m_done_cnt, m_to_cnt;
    logic              m_ack_s, m_done_s;
    logic [DATA_W-1:0] m_slice;
    logic [2:0]        exp_req;
    logic              exp_stall;

    always_comb begin
        m_ack_s  = 1'b0;
        m_done_s = 1'b0;
        m_slice  = '0;
        exp_req  = '0;
        for (int k = 0; k < 3; k++) begin
            if (int'(m_kind) == k + 1) begin
                m_ack_s  = bus.acc_ack_i[k];
                m_done_s = bus.acc_done_i[k];
                m_slice  = bus.acc_res_i[k*DATA_W +: DATA_W];
                if (m_busy && !m_acked && !m_resp) exp_req[k] = 1'b1;
            end
        end
        exp_stall = m_busy ? !m_resp : (bus.cpu_valid_i && bus.cpu_kind_i != NONE);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_acked <= 0; m_resp <= 0; m_err <= 0; m_age <= 0;
            m_kind <= NONE; m_a <= '0; m_b <= '0; m_res <= '0;
            m_done_cnt <= 0; m_to_cnt <= 0;
        end else if (m_resp) begin
            m_resp <= 0;
            m_busy <= 0;
            if (m_err) m_to_cnt <= (m_to_cnt < 65535) ? m_to_cnt + 1 : m_to_cnt;
            else       m_done_cnt <= (m_done_cnt < 65535) ? m_done_cnt + 1 : m_done_cnt;
        end else if (m_busy) begin
            m_age <= m_age + 1;
            if (m_done_s && (m_acked || m_ack_s)) begin
                m_resp <= 1; m_err <= 0; m_res <= m_slice;
            end else if (m_age == T - 1) begin
                m_resp <= 1; m_err <= 1; m_res <= '0;
            end else if (m_ack_s) begin
                m_acked <= 1;
            end
        end else if (bus.cpu_valid_i && bus.cpu_kind_i != NONE) begin
            m_busy <= 1; m_acked <= 0; m_age <= 0;
            m_kind <= bus.cpu_kind_i; m_a <= bus.cpu_opr_a_i; m_b <= bus.cpu_opr_b_i;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            check("stall", bus.cpu_stall_o, exp_stall);
            check("res_valid", bus.cpu_res_valid_o, m_resp);
            if (m_resp) begin
                check("res", bus.cpu_res_o, m_res);
                check("err", bus.cpu_err_o, m_err);
            end
            check("acc_req", bus.acc_req_o, exp_req);
            check("busy", busy, m_busy);
            if (m_busy) begin
                check("opr_a", bus.acc_opr_a_o, m_a);
                check("opr_b", bus.acc_opr_b_o, m_b);
            end
`ifdef SCHED_PERF_CNT_EN
            check("perf_done", perf_done, m_done_cnt);
            check("perf_to", perf_to, m_to_cnt);
`else
            check("perf_done", perf_done, 0);
            check("perf_to", perf_to, 0);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_acc();
        bus.acc_ack_i  = '0;
        bus.acc_done_i = '0;
        bus.acc_res_i  = '0;
    endtask

    // Presents one op, then drives ack/done on the given ISSUE/WAIT cycle
    // numbers (0 = never) and checks the strobe. Returns at the start of the
    // cycle after the strobe, so consecutive calls are back-to-back.
    task automatic run_op(input string name, input custom_instr_t kind,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input int ack_at, input int done_at, input logic [DATA_W-1:0] res,
                          input int spur_at, input logic [2:0] spur_mask,
                          input logic [DATA_W-1:0] spur_res,
                          input int exp_lat, input logic [DATA_W-1:0] exp_res,
                          input logic exp_err);
        int k;
        int lat;
        logic [DATA_W-1:0] got_res;
        logic got_err, got_stall;
        logic [2:0] got_req;
        k   = int'(kind) - 1;
        lat = -1;
        got_res = '0; got_err = 0; got_stall = 0; got_req = '0;
        bus.cpu_valid_i = 1'b1;
        bus.cpu_kind_i  = kind;
        bus.cpu_opr_a_i = a;
        bus.cpu_opr_b_i = b;
        @(negedge clk);
        check({name, " accept stall"}, bus.cpu_stall_o, 1'b1);
        @(posedge clk); #1;
        bus.cpu_valid_i = 1'b0;
        bus.cpu_kind_i  = NONE;
        for (int i = 1; i <= 40; i++) begin
            clear_acc();
            if (i == ack_at) bus.acc_ack_i[k] = 1'b1;
            if (i == done_at) begin
                bus.acc_done_i[k] = 1'b1;
                bus.acc_res_i[k*DATA_W +: DATA_W] = res;
            end
            if (i == spur_at) begin
                for (int u = 0; u < 3; u++) begin
                    if (spur_mask[u]) begin
                        bus.acc_done_i[u] = 1'b1;
                        bus.acc_res_i[u*DATA_W +: DATA_W] = spur_res;
                    end
                end
            end
            @(negedge clk);
            if (bus.cpu_res_valid_o) begin
                lat = i; got_res = bus.cpu_res_o; got_err = bus.cpu_err_o;
                got_req = bus.acc_req_o; got_stall = bus.cpu_stall_o;
            end
            @(posedge clk); #1;
            clear_acc();
            if (lat >= 0) break;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " result"}, got_res, exp_res);
        check({name, " error"}, got_err, exp_err);
        check({name, " req at strobe"}, got_req, 3'b000);
        check({name, " stall at strobe"}, got_stall, 1'b0);
    endtask

    initial begin
        bus.cpu_valid_i = 1'b0;
        bus.cpu_kind_i  = NONE;
        bus.cpu_opr_a_i = '0;
        bus.cpu_opr_b_i = '0;
        clear_acc();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst stall", bus.cpu_stall_o, 1'b0);
        check("rst res_valid", bus.cpu_res_valid_o, 1'b0);
        check("rst res", bus.cpu_res_o, 0);
        check("rst err", bus.cpu_err_o, 1'b0);
        check("rst req", bus.acc_req_o, 3'b000);
        check("rst opr_a", bus.acc_opr_a_o, 0);
        check("rst busy", busy, 1'b0);
        check("rst perf", {perf_done, perf_to}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // kind NONE is ignored
        bus.cpu_valid_i = 1'b1;
        @(negedge clk);
        check("none stall", bus.cpu_stall_o, 1'b0);
        @(posedge clk); #1;
        bus.cpu_valid_i = 1'b0;
        check("none busy", busy, 1'b0);

        // reset while waiting for done
        bus.cpu_valid_i = 1'b1;
        bus.cpu_kind_i  = ENCRYPT;
        bus.cpu_opr_a_i = 19'h00100;
        bus.cpu_opr_b_i = 19'h00200;
        @(posedge clk); #1;
        bus.cpu_valid_i = 1'b0;
        bus.cpu_kind_i  = NONE;
        bus.acc_ack_i   = 3'b010;
        @(posedge clk); #1;
        clear_acc();
        check("wait busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("wait rst req", bus.acc_req_o, 3'b000);
        check("wait rst busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus.acc_done_i = 3'b010;
        bus.acc_res_i[1*DATA_W +: DATA_W] = 19'h7FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post rst no strobe", bus.cpu_res_valid_o, 1'b0);
            @(posedge clk); #1;
            clear_acc();
        end
        run_op("enc after rst", ENCRYPT, 19'h00111, 19'h00222, 1, 2, 19'h0ABCD,
               0, 3'b000, '0, 3, 19'h0ABCD, 1'b0);
        // immediately back-to-back
        run_op("b2b dec", DECRYPT, 19'h00333, 19'h00444, 1, 1, 19'h3FFFF,
               0, 3'b000, '0, 2, 19'h3FFFF, 1'b0);

        // reset during ISSUE drops the request asynchronously
        bus.cpu_valid_i = 1'b1;
        bus.cpu_kind_i  = FFT;
        @(posedge clk); #1;
        bus.cpu_valid_i = 1'b0;
        bus.cpu_kind_i  = NONE;
        check("issue req", bus.acc_req_o, 3'b001);
        reset_n = 1'b0;
        #1;
        check("issue rst req", bus.acc_req_o, 3'b000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("fft", FFT, 19'h00012, 19'h00034, 1, 4, 19'h7ABCD,
               0, 3'b000, '0, 5, 19'h7ABCD, 1'b0);
        run_op("enc fast", ENCRYPT, 19'h00001, 19'h00002, 1, 1, 19'h00555,
               0, 3'b000, '0, 2, 19'h00555, 1'b0);
        run_op("dec timeout", DECRYPT, 19'h00003, 19'h00004, 1, 0, '0,
               0, 3'b000, '0, 9, 19'h00000, 1'b1);
        run_op("fft spurious", FFT, 19'h00005, 19'h00006, 1, 3, 19'h22222,
               2, 3'b010, 19'h11111, 4, 19'h22222, 1'b0);
`ifdef SCHED_PERF_CNT_EN
        check("perf done lit", perf_done, 16'd3);
        check("perf to lit", perf_to, 16'd1);
`else
        check("perf done lit", perf_done, 16'd0);
        check("perf to lit", perf_to, 16'd0);
`endif
        // done without ack in ISSUE is ignored; op times out still in ISSUE
        run_op("issue timeout", FFT, 19'h00007, 19'h00008, 0, 3, 19'h12345,
               0, 3'b000, '0, 9, 19'h00000, 1'b1);
        // done on the terminal cycle wins over the timeout
        run_op("done at tc", DECRYPT, 19'h00009, 19'h0000A, 1, 8, 19'h13579,
               0, 3'b000, '0, 9, 19'h13579, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/custom_instr_sched.md
Name: custom_instr_sched

Overview:
Controller that sequences the three custom-instruction accelerators (FFT, ENCRYPT, DECRYPT) for the 19-bit CPU.
- Accepts one custom op from decode/execute and stalls the CPU while the op runs.
- Dispatches the op to the selected unit over a req/ack handshake and waits for done.
- Returns the 19-bit result (or an error on timeout) for the CPU's MEM-path write-back mux.

Parameters:
DATA_W, 19, datapath width of operands and results
TIMEOUT_CYCLES, 64, maximum cycles spent in ISSUE+WAIT before the op is aborted (legal range 2..65535)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
cpu_valid_i  input  1  custom op presented this cycle
cpu_kind_i  input  2  custom_instr_t: 0 NONE, 1 FFT, 2 ENCRYPT, 3 DECRYPT
cpu_opr_a_i  input  DATA_W  operand A
cpu_opr_b_i  input  DATA_W  operand B
cpu_stall_o  output  1  hold PC/pipeline
cpu_res_valid_o  output  1  one-cycle result strobe
cpu_res_o  output  DATA_W  result, valid with strobe
cpu_err_o  output  1  timeout flag, valid with strobe
acc_req_o  output  3  one-hot request, bit0 FFT, bit1 ENCRYPT, bit2 DECRYPT
acc_opr_a_o  output  DATA_W  latched operand A to all units
acc_opr_b_o  output  DATA_W  latched operand B to all units
acc_ack_i  input  3  per-unit request accepted
acc_done_i  input  3  per-unit result ready, single-cycle pulse
acc_res_i  input  3*DATA_W  per-unit results, unit k at bits [k*DATA_W +: DATA_W]
busy_o  output  1  state != IDLE
perf_done_cnt_o  output  16  completed ops (see Optional Feature)
perf_timeout_cnt_o  output  16  timed-out ops (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; latched kind, operands, result, error and timer cleared. Reset mid-op drops acc_req_o asynchronously. In-flight op is lost and no strobe is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On cpu_valid_i=1 with kind != NONE: latch kind and operands, go to ISSUE.
  - cpu_stall_o is combinationally 1 in this cycle: stall = (state!=IDLE && state!=RESP) | (state==IDLE & cpu_valid_i & kind!=NONE).
  - cpu_valid_i with kind NONE is ignored; no stall.
- ISSUE:
  - acc_req_o = onehot(kind). Held stable, with stable operands, until acc_ack_i[kind] is seen.
  - On ack: go to WAIT.
  - On ack and done of the selected unit in the same cycle: latch acc_res_i slice, go to RESP.
- WAIT:
  - acc_req_o = 0.
  - On acc_done_i[kind]: latch result slice, err=0, go to RESP.
- Ignored inputs: ack/done bits from non-selected units are ignored in every state; done seen in IDLE or RESP is ignored.
- Timeout:
  - Timer clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - When timer == TIMEOUT_CYCLES-1 and no qualifying event occurs that cycle: result=0, err=1, drop request, go to RESP.
  - A qualifying done in that same cycle wins: normal result, err=0.
- RESP: cpu_res_valid_o=1 for exactly one cycle with cpu_res_o/cpu_err_o; cpu_stall_o=0 so the CPU retires the op; next state IDLE.
- Back-to-back: a new op is accepted in the first IDLE cycle after RESP.
- cpu_valid_i outside IDLE is ignored, since the CPU is stalled.
- Latency: minimum 2 cycles from accept to strobe (ack+done on first ISSUE cycle); maximum TIMEOUT_CYCLES+1.
- Outputs acc_opr_*_o always reflect the latched registers.

Optional Feature:
Macro SCHED_PERF_CNT_EN.
- Defined: two 16-bit saturating counters, incremented on RESP (done with err=0 vs err=1), cleared only by reset, driven to perf_done_cnt_o and perf_timeout_cnt_o.
- Undefined: counters are not built and both ports are tied to 0.
- Core timing and behaviour are identical in both cases.

Decomposition:
- Package pkgs gets:
  - typedef enum logic [1:0] custom_instr_t {NONE, FFT, ENCRYPT, DECRYPT}, shared with control and the top-level result mux.
  - typedef enum sched_state_t {IDLE, ISSUE, WAIT, RESP}.
  - localparam NUM_ACC = 3.
- One sub-module: sched_timeout_ctr (clear, enable, terminal-count output, width from $clog2(TIMEOUT_CYCLES)).

Test Plan:
- FFT, A=19'h00012, B=19'h00034; ack on cycle 1 of ISSUE, done 3 cycles later with res 19'h7ABCD -> strobe one cycle later, cpu_res_o=19'h7ABCD, err=0, stall high from accept through WAIT.
- ENCRYPT, with ack and done both in the first ISSUE cycle, res 19'h00555 -> RESP on the next cycle; total 2 cycles accept-to-strobe.
- DECRYPT, never done, TIMEOUT_CYCLES=8 -> strobe with res=0, err=1 exactly 9 cycles after accept; acc_req_o=0 after abort.
- FFT in WAIT, spurious acc_done_i[1] with res 19'h11111 -> ignored; later done[0] with 19'h22222 returns 19'h22222.
- reset_n low during WAIT -> acc_req_o=0, state IDLE; after release, no strobe occurs and a new ENCRYPT op completes normally.
- With SCHED_PERF_CNT_EN: 3 good ops + 1 timeout -> perf_done_cnt_o=3, perf_timeout_cnt_o=1; without the macro both read 0.
